// File: rtl/sample_pacer.sv
// Sample pacer: buffers upstream samples in a small FIFO and releases
// them as a one-cycle strobe every CLK_PER_SAMPLE clocks once prefilled.
module sample_pacer #(
    parameter int DATA_WIDTH     = 16,
    parameter int CLK_PER_SAMPLE = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int PREFILL        = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             sample_valid_o,
    output logic                             underrun_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LW-1:0]         level_q, level_d;
    logic [AW-1:0]         wr_q, wr_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sv_q, sv_d;
    logic                  und_q, und_d;
    logic                  push;
    logic                  slot;
    logic                  pop;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_comb begin
        push    = valid_i && ready_q;
        slot    = (state_q == RUN) && (cnt_q == '0);
        pop     = slot && (level_q != '0);
        level_d = level_q + LW'(push) - LW'(pop);
        ready_d = level_d < LW'(FIFO_DEPTH);
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        state_d = state_q;
        cnt_d   = '0;
        data_d  = data_q;
        sv_d    = 1'b0;
        und_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q >= LW'(PREFILL)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (slot && !pop) begin
                    und_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(CLK_PER_SAMPLE - 1)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Output comes from storage only, so a same-cycle push never falls through.
                if (pop) begin
                    data_d = mem_q[rd_q];
                    sv_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            sv_q    <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            sv_q    <= sv_d;
            und_q   <= und_d;
        end
    end

    assign ready_o        = ready_q;
    assign data_o         = data_q;
    assign sample_valid_o = sv_q;
    assign underrun_o     = und_q;
    assign level_o        = level_q;

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: two instances (paced and every-cycle) checked
// against a queue-based slot model plus hand-computed expectations.
module tb_sample_pacer;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] din   = '0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic        rdy [2];
    logic        svo [2];
    logic        und [2];
    logic [15:0] dout [2];
    logic [3:0]  lvl [2];

    logic [15:0] got0 [$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int CPS = (g == 0) ? 4 : 1;
        localparam int PRE = (g == 0) ? 2 : 8;
        localparam int DEP = 8;

        sample_pacer #(
            .DATA_WIDTH(16),
            .CLK_PER_SAMPLE(CPS),
            .FIFO_DEPTH(DEP),
            .PREFILL(PRE)
        ) dut (
            .clk_i(clk),
            .rst_i(rst),
            .data_i(din),
            .valid_i(valid),
            .ready_o(rdy[g]),
            .data_o(dout[g]),
            .sample_valid_o(svo[g]),
            .underrun_o(und[g]),
            .level_o(lvl[g])
        );

        // Model: a queue of samples and the absolute cycle of the next due slot.
        logic [15:0] q [$];
        bit          run    = 1'b0;
        longint      cyc    = 0;
        longint      nslot  = 0;
        logic [15:0] m_data = '0;
        bit          m_sv   = 1'b0;
        bit          m_und  = 1'b0;
        bit          m_rdy  = 1'b0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                run    = 1'b0;
                cyc    = 0;
                nslot  = 0;
                m_data = '0;
                m_sv   = 1'b0;
                m_und  = 1'b0;
                m_rdy  = 1'b0;
            end else begin
                bit push;
                bit was_run;
                int pre_n;
                push    = valid && m_rdy;
                was_run = run;
                pre_n   = q.size();
                m_sv    = 1'b0;
                m_und   = 1'b0;
                if (run && cyc == nslot) begin
                    if (pre_n > 0) begin
                        m_data = q.pop_front();
                        m_sv   = 1'b1;
                        nslot  = cyc + CPS;
                    end else begin
                        m_und = 1'b1;
                        run   = 1'b0;
                    end
                end
                if (push) q.push_back(din);
                if (!was_run && pre_n >= PRE) begin
                    run   = 1'b1;
                    nslot = cyc + 1;
                end
                m_rdy = q.size() < DEP;
                cyc++;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                cmp($sformatf("u%0d.data", g), dout[g], m_data);
                cmp($sformatf("u%0d.strobe", g), svo[g], m_sv);
                cmp($sformatf("u%0d.underrun", g), und[g], m_und);
                cmp($sformatf("u%0d.level", g), lvl[g], q.size());
                cmp($sformatf("u%0d.ready", g), rdy[g], m_rdy);
            end
        end
    end

    always @(negedge clk) begin
        if (svo[0]) got0.push_back(dout[0]);
    end

    initial begin
        logic [15:0] exp33 [6];
        int dens;
        exp33 = '{16'd7, 16'd8, 16'h8000, 16'h7fff, 16'h0000, 16'hffff};
        dens  = 50;

        repeat (3) @(posedge clk);
        #1;
        cmp("rst_ready", rdy[0], 0);
        cmp("rst_level", lvl[0], 0);
        cmp("rst_strobe", svo[0], 0);
        chk_en = 1'b1;
        rst = 1'b0;
        step();
        cmp("ready_rise", rdy[0], 1);

        // Three pushes, three paced outputs, then an underrun.
        valid = 1'b1; din = 16'd100; step();
        din = 16'hff38; step();
        din = 16'd300;  step();
        valid = 1'b0;
        step();
        cmp("s1_strobe", svo[0], 1);
        cmp("s1_data", dout[0], 100);
        cmp("s1_level", lvl[0], 2);
        step();
        cmp("s1_single", svo[0], 0);
        repeat (3) step();
        cmp("s2_strobe", svo[0], 1);
        cmp("s2_data", dout[0], 16'hff38);
        repeat (4) step();
        cmp("s3_strobe", svo[0], 1);
        cmp("s3_data", dout[0], 300);
        cmp("s3_level", lvl[0], 0);
        repeat (4) step();
        cmp("ur_pulse", und[0], 1);
        cmp("ur_nostrobe", svo[0], 0);
        cmp("ur_hold", dout[0], 300);
        step();
        cmp("ur_once", und[0], 0);
        repeat (5) step();
        cmp("idle_quiet", svo[0], 0);

        // Restart after two pushes, then extreme values in order.
        valid = 1'b1; din = 16'd7; step();
        din = 16'd8; step();
        valid = 1'b0; step();
        cmp("re_wait", svo[0], 0);
        step();
        cmp("re_strobe", svo[0], 1);
        cmp("re_data", dout[0], 7);
        got0.delete();
        valid = 1'b1;
        din = 16'h8000; step();
        din = 16'h7fff; step();
        din = 16'h0000; step();
        din = 16'hffff; step();
        valid = 1'b0;
        repeat (30) step();
        cmp("ext_count", got0.size(), 6);
        for (int i = 0; i < 6; i++) cmp($sformatf("ext_%0d", i), got0[i], exp33[i]);

        // Async reset in RUN with level 3 and a strobe in flight.
        valid = 1'b1;
        din = 16'd11; step();
        din = 16'd12; step();
        din = 16'd13; step();
        din = 16'd14; step();
        valid = 1'b0;
        cmp("pr_strobe", svo[0], 1);
        cmp("pr_level", lvl[0], 3);
        #2 rst = 1'b1;
        #1;
        cmp("ar_strobe", svo[0], 0);
        cmp("ar_data", dout[0], 0);
        cmp("ar_level", lvl[0], 0);
        cmp("ar_ready", rdy[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        cmp("ar_rdy_rise", rdy[0], 1);
        repeat (6) step();
        cmp("ar_nostrobe", svo[0], 0);
        cmp("ar_lost", lvl[0], 0);
        valid = 1'b1; din = 16'd21; step();
        din = 16'd22; step();
        valid = 1'b0; step();
        cmp("ar_wait", svo[0], 0);
        step();
        cmp("ar_restart", dout[0], 21);

        // Full FIFO back-pressure and every-cycle strobes on u1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = 16'(1000 + i);
            step();
        end
        cmp("full_level", lvl[1], 8);
        cmp("full_ready", rdy[1], 0);
        din = 16'd1009;
        step();
        cmp("full_hold", lvl[1], 8);
        step();
        cmp("pop_strobe", svo[1], 1);
        cmp("pop_data", dout[1], 1001);
        cmp("pop_level", lvl[1], 7);
        cmp("pop_ready", rdy[1], 1);
        din = 16'd1010;
        step();
        cmp("ninth_level", lvl[1], 7);
        cmp("ninth_data", dout[1], 1002);
        for (int i = 0; i < 20; i++) begin
            din = 16'(2000 + i);
            step();
            cmp("cps1_strobe", svo[1], 1);
            cmp("cps1_level", lvl[1], 7);
            cmp("cps1_underrun", und[1], 0);
        end

        // Randomised traffic with varying density and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) dens = int'($urandom_range(5, 100));
            valid = ($urandom_range(1, 100) <= dens);
            din = 16'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
            step();
        end
        valid = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
